// File: rtl/buzzer_sched.sv
// ============================================================================
// Module   : buzzer_sched
// Brief    : Three-source buzzer pattern scheduler. Arbitration is fixed
//            priority and non-preemptive. Each source has its own on/off/repeat
//            pattern, timed in ticks of TICK_DIV clock cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module buzzer_sched #(
   parameter int TICK_DIV = 25000000,
   parameter int ON_T0    = 1,
   parameter int OFF_T0   = 1,
   parameter int REP0     = 4,
   parameter int ON_T1    = 2,
   parameter int OFF_T1   = 2,
   parameter int REP1     = 2,
   parameter int ON_T2    = 1,
   parameter int OFF_T2   = 3,
   parameter int REP2     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
   input  logic       mute,
   output logic       buzzer,
   output logic [2:0] grant,
   output logic [2:0] done,
   output logic       busy
);

   localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GRANT = 3'd1,
      S_ON    = 3'd2,
      S_OFF   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    prev_req_q;
   logic [2:0]    arm_q;
   logic [2:0]    pending_q, pending_d;
   logic [1:0]    sel_q, sel_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    phase_q, phase_d;
   logic [7:0]    rep_q, rep_d;
   logic          buzzer_q;
   logic [2:0]    grant_q, grant_d;
   logic [2:0]    done_q, done_d;

   logic [2:0]    w_edge;
   logic [2:0]    w_clr;
   logic          w_tick;
   logic          w_phase_end;
   logic [7:0]    w_rep_dec;
   logic [1:0]    w_lowest;

   function automatic logic [7:0] on_ticks(input logic [1:0] s);
      case (s)
         2'd0:    return 8'(ON_T0);
         2'd1:    return 8'(ON_T1);
         default: return 8'(ON_T2);
      endcase
   endfunction

   function automatic logic [7:0] off_ticks(input logic [1:0] s);
      case (s)
         2'd0:    return 8'(OFF_T0);
         2'd1:    return 8'(OFF_T1);
         default: return 8'(OFF_T2);
      endcase
   endfunction

   function automatic logic [7:0] rep_count(input logic [1:0] s);
      case (s)
         2'd0:    return 8'(REP0);
         2'd1:    return 8'(REP1);
         default: return 8'(REP2);
      endcase
   endfunction

   // arm_q blocks a request that was already high when reset released, until
   // that request has been seen low at least once.
   assign w_edge      = req & ~prev_req_q & arm_q;
   assign w_tick      = (presc_q == PRESC_MAX);
   assign w_phase_end = w_tick && (phase_q <= 8'd1);
   assign w_rep_dec   = (rep_q != 8'd0) ? rep_q - 8'd1 : 8'd0;
   assign w_lowest    = pending_q[0] ? 2'd0 : (pending_q[1] ? 2'd1 : 2'd2);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      presc_d = presc_q;
      phase_d = phase_q;
      rep_d   = rep_q;
      w_clr   = 3'b000;

      if (state_q == S_ON || state_q == S_OFF) begin
         presc_d = w_tick ? '0 : presc_q + 1'b1;
         if (w_tick && phase_q != 8'd0) begin
            phase_d = phase_q - 8'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (pending_q != 3'b000 && !mute) begin
               state_d = S_GRANT;
               sel_d   = w_lowest;
            end
         end
         S_GRANT: begin
            w_clr   = 3'(3'b001 << sel_q);
            phase_d = on_ticks(sel_q);
            rep_d   = rep_count(sel_q);
            presc_d = '0;
            state_d = S_ON;
         end
         S_ON: begin
            if (w_phase_end) begin
               state_d = S_OFF;
               phase_d = off_ticks(sel_q);
               presc_d = '0;
            end
         end
         S_OFF: begin
            if (w_phase_end) begin
               rep_d = w_rep_dec;
               if (w_rep_dec != 8'd0) begin
                  state_d = S_ON;
                  phase_d = on_ticks(sel_q);
                  presc_d = '0;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (mute && state_q != S_IDLE) begin
         state_d = S_IDLE;
      end
   end

   // A new edge on the bit being cleared by GRANT takes precedence.
   assign pending_d = mute ? 3'b000 : ((pending_q & ~w_clr) | w_edge);
   assign grant_d   = (state_d == S_IDLE) ? 3'b000 : 3'(3'b001 << sel_d);
   assign done_d    = (state_d == S_DONE) ? 3'(3'b001 << sel_d) : 3'b000;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         prev_req_q <= 3'b000;
         arm_q      <= ~req;
         pending_q  <= 3'b000;
         sel_q      <= 2'd0;
         presc_q    <= '0;
         phase_q    <= 8'd0;
         rep_q      <= 8'd0;
         buzzer_q   <= 1'b0;
         grant_q    <= 3'b000;
         done_q     <= 3'b000;
      end else begin
         state_q    <= state_d;
         prev_req_q <= req;
         arm_q      <= arm_q | ~req;
         pending_q  <= pending_d;
         sel_q      <= sel_d;
         presc_q    <= presc_d;
         phase_q    <= phase_d;
         rep_q      <= rep_d;
         buzzer_q   <= (state_d == S_ON);
         grant_q    <= grant_d;
         done_q     <= done_d;
      end
   end

   assign buzzer = buzzer_q;
   assign grant  = grant_q;
   assign done   = done_q;
   assign busy   = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_buzzer_sched.sv
// ============================================================================
// Module   : tb_buzzer_sched
// Brief    : Directed self-checking bench for buzzer_sched (TICK_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_buzzer_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] req;
   logic       mute;
   logic       buzzer;
   logic [2:0] grant;
   logic [2:0] done;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   buzzer_sched #(.TICK_DIV(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .mute   (mute),
      .buzzer (buzzer),
      .grant  (grant),
      .done   (done),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 3'b000; mute = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (buzzer !== 1'b0 || grant !== 3'b000 || done !== 3'b000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold buz=%b gnt=%b done=%b busy=%b required all 0", buzzer, grant, done, busy);
         end
      end
      rst = 1'b0;
      step();
      checks++;
      if (buzzer !== 1'b0 || grant !== 3'b000 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release buz=%b gnt=%b busy=%b required 0/000/0", buzzer, grant, busy);
      end
   endtask

   // Source 1: 2 repeats of 8 high / 8 low
   task automatic test_single();
      req = 3'b010;
      step();
      checks++;
      if (grant !== 3'b000 || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_pre gnt=%b busy=%b required 000/0", grant, busy);
      end
      req = 3'b000;
      step();
      checks++;
      if (grant !== 3'b010 || busy !== 1'b1 || buzzer !== 1'b0) begin
         failures++;
         $display("FAIL single_grant gnt=%b busy=%b buz=%b required 010/1/0", grant, busy, buzzer);
      end
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (buzzer !== (i < 8) || grant !== 3'b010 || done !== 3'b000) begin
               failures++;
               $display("FAIL single_pat r=%0d i=%0d buz=%b gnt=%b done=%b required buz=%b gnt=010", r, i, buzzer, grant, done, (i < 8));
            end
         end
      end
      step();
      checks++;
      if (done !== 3'b010 || buzzer !== 1'b0) begin
         failures++;
         $display("FAIL single_done done=%b buz=%b required 010/0", done, buzzer);
      end
      step();
      checks++;
      if (done !== 3'b000 || grant !== 3'b000 || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_idle done=%b gnt=%b busy=%b required 000/000/0", done, grant, busy);
      end
   endtask

   // Simultaneous req[0] and req[2]: source 0 first, then source 2
   task automatic test_priority();
      req = 3'b101;
      step();
      req = 3'b000;
      step();
      checks++;
      if (grant !== 3'b001) begin
         failures++;
         $display("FAIL prio_grant0 gnt=%b required 001", grant);
      end
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (buzzer !== (i < 4) || grant !== 3'b001) begin
               failures++;
               $display("FAIL prio_pat0 r=%0d i=%0d buz=%b gnt=%b required buz=%b gnt=001", r, i, buzzer, grant, (i < 4));
            end
         end
      end
      step();
      checks++;
      if (done !== 3'b001) begin
         failures++;
         $display("FAIL prio_done0 done=%b required 001", done);
      end
      step();
      checks++;
      if (grant !== 3'b000 || busy !== 1'b0 || done !== 3'b000) begin
         failures++;
         $display("FAIL prio_gap gnt=%b busy=%b done=%b required 000/0/000", grant, busy, done);
      end
      step();
      checks++;
      if (grant !== 3'b100) begin
         failures++;
         $display("FAIL prio_grant2 gnt=%b required 100", grant);
      end
      for (int i = 0; i < 16; i++) begin
         step();
         checks++;
         if (buzzer !== (i < 4) || grant !== 3'b100) begin
            failures++;
            $display("FAIL prio_pat2 i=%0d buz=%b gnt=%b required buz=%b gnt=100", i, buzzer, grant, (i < 4));
         end
      end
      step();
      checks++;
      if (done !== 3'b100) begin
         failures++;
         $display("FAIL prio_done2 done=%b required 100", done);
      end
      step();
      checks++;
      if (busy !== 1'b0 || grant !== 3'b000) begin
         failures++;
         $display("FAIL prio_idle busy=%b gnt=%b required 0/000", busy, grant);
      end
   endtask

   // req[0] rises during source-2 ON: no preemption, served right after
   task automatic test_nonpreempt();
      req = 3'b100;
      step();
      req = 3'b000;
      step();
      checks++;
      if (grant !== 3'b100) begin
         failures++;
         $display("FAIL np_grant2 gnt=%b required 100", grant);
      end
      for (int i = 0; i < 16; i++) begin
         req = (i == 1) ? 3'b001 : 3'b000;
         step();
         checks++;
         if (buzzer !== (i < 4) || grant !== 3'b100 || done !== 3'b000) begin
            failures++;
            $display("FAIL np_pat2 i=%0d buz=%b gnt=%b done=%b required buz=%b gnt=100", i, buzzer, grant, done, (i < 4));
         end
      end
      req = 3'b000;
      step();
      checks++;
      if (done !== 3'b100) begin
         failures++;
         $display("FAIL np_done2 done=%b required 100", done);
      end
      step();
      checks++;
      if (grant !== 3'b000 || busy !== 1'b0) begin
         failures++;
         $display("FAIL np_gap gnt=%b busy=%b required 000/0", grant, busy);
      end
      step();
      checks++;
      if (grant !== 3'b001) begin
         failures++;
         $display("FAIL np_grant0 gnt=%b required 001", grant);
      end
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (buzzer !== (i < 4) || grant !== 3'b001) begin
               failures++;
               $display("FAIL np_pat0 r=%0d i=%0d buz=%b gnt=%b required buz=%b", r, i, buzzer, grant, (i < 4));
            end
         end
      end
      step();
      checks++;
      if (done !== 3'b001) begin
         failures++;
         $display("FAIL np_done0 done=%b required 001", done);
      end
      step();
   endtask

   // mute in 3rd ON cycle of source 1; edge during mute discarded
   task automatic test_mute();
      req = 3'b010;
      step();
      req = 3'b000;
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (buzzer !== 1'b1) begin
            failures++;
            $display("FAIL mute_on i=%0d buz=%b required 1", i, buzzer);
         end
      end
      mute = 1'b1;
      step();
      checks++;
      if (buzzer !== 1'b0 || busy !== 1'b0 || grant !== 3'b000 || done !== 3'b000) begin
         failures++;
         $display("FAIL mute_abort buz=%b busy=%b gnt=%b done=%b required 0/0/000/000", buzzer, busy, grant, done);
      end
      req = 3'b010;
      step();
      req = 3'b000;
      step();
      mute = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (busy !== 1'b0 || grant !== 3'b000 || done !== 3'b000 || buzzer !== 1'b0) begin
            failures++;
            $display("FAIL mute_after i=%0d busy=%b gnt=%b done=%b buz=%b required idle", i, busy, grant, done, buzzer);
         end
      end
   endtask

   // rst mid-OFF of source 0 while req[1] is pending
   task automatic test_reset_mid();
      req = 3'b001;
      step();
      req = 3'b000;
      step();
      for (int i = 0; i < 6; i++) begin
         req = (i == 0) ? 3'b010 : 3'b000;
         step();
         checks++;
         if (buzzer !== (i < 4) || grant !== 3'b001) begin
            failures++;
            $display("FAIL rmid_pat i=%0d buz=%b gnt=%b required buz=%b gnt=001", i, buzzer, grant, (i < 4));
         end
      end
      req = 3'b000;
      rst = 1'b1;
      step();
      checks++;
      if (buzzer !== 1'b0 || grant !== 3'b000 || done !== 3'b000 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rmid_reset buz=%b gnt=%b done=%b busy=%b required all 0", buzzer, grant, done, busy);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (busy !== 1'b0 || grant !== 3'b000 || done !== 3'b000) begin
            failures++;
            $display("FAIL rmid_after i=%0d busy=%b gnt=%b done=%b required idle", i, busy, grant, done);
         end
      end
   endtask

   // req held high across reset release is not an edge
   task automatic test_reset_held();
      rst = 1'b1;
      req = 3'b010;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (busy !== 1'b0 || grant !== 3'b000) begin
            failures++;
            $display("FAIL rheld_quiet i=%0d busy=%b gnt=%b required 0/000", i, busy, grant);
         end
      end
      req = 3'b000;
      step();
      req = 3'b010;
      step();
      req = 3'b000;
      step();
      checks++;
      if (grant !== 3'b010 || busy !== 1'b1) begin
         failures++;
         $display("FAIL rheld_edge gnt=%b busy=%b required 010/1", grant, busy);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   // req[1] re-pulsed as its GRANT clears pending: exactly one extra run
   task automatic test_back_to_back();
      req = 3'b010;
      step();
      req = 3'b000;
      step();
      checks++;
      if (grant !== 3'b010) begin
         failures++;
         $display("FAIL b2b_grant1 gnt=%b required 010", grant);
      end
      for (int run = 0; run < 2; run++) begin
         for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) begin
               req = (run == 0 && r == 0 && i == 0) ? 3'b010 : 3'b000;
               step();
               checks++;
               if (buzzer !== (i < 8) || grant !== 3'b010) begin
                  failures++;
                  $display("FAIL b2b_pat run=%0d r=%0d i=%0d buz=%b gnt=%b required buz=%b", run, r, i, buzzer, grant, (i < 8));
               end
            end
         end
         req = 3'b000;
         step();
         checks++;
         if (done !== 3'b010) begin
            failures++;
            $display("FAIL b2b_done run=%0d done=%b required 010", run, done);
         end
         step();
         checks++;
         if (busy !== 1'b0 || grant !== 3'b000) begin
            failures++;
            $display("FAIL b2b_gap run=%0d busy=%b gnt=%b required 0/000", run, busy, grant);
         end
         if (run == 0) begin
            step();
            checks++;
            if (grant !== 3'b010) begin
               failures++;
               $display("FAIL b2b_regrant gnt=%b required 010", grant);
            end
         end
      end
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (busy !== 1'b0 || grant !== 3'b000) begin
            failures++;
            $display("FAIL b2b_after i=%0d busy=%b gnt=%b required 0/000", i, busy, grant);
         end
      end
   endtask

   initial begin
      rst  = 1'b1;
      req  = 3'b000;
      mute = 1'b0;
      test_reset();
      test_single();
      test_priority();
      test_nonpreempt();
      test_mute();
      test_reset_mid();
      test_reset_held();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule

`default_nettype wire
